// File: rtl/sram_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_stream_reader: burst reads from a 1-cycle sram, streamed out via    |
// | a 2-entry skid FIFO.                                       Revision 1.0  |
// +--------------------------------------------------------------------------+
module sram_stream_reader #(
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_a_hold;
  logic [LEN_W-1:0]  r_rem;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic              w_issue;
  logic              w_final_issue;
  logic [2:0]        w_occ;

  // Occupancy after this cycle's pop; keeping it below 2 before an issue
  // guarantees the returning word always has a FIFO slot.
  assign w_pop         = (r_count != 2'd0) && out_ready;
  assign w_push        = r_inflight;
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  assign w_issue       = (r_state == S_RUN) && (w_occ < 3'd2);
  assign w_final_issue = w_issue && (r_rem == LEN_W'(1));

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (w_accept && (cmd_len != '0)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_final_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_occ == 3'd0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_addr          <= '0;
      r_a_hold        <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_last     <= 2'b00;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_rem  <= cmd_len;
      end else if (w_issue) begin
        r_addr   <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        r_rem    <= r_rem - 1'b1;
        r_a_hold <= r_addr;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_final_issue;
      if (w_push) begin
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_fifo_data[r_wr_ptr] <= Q;
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = out_valid && r_fifo_last[r_rd_ptr];
  assign CEN       = ~w_issue;
  assign WEN       = 1'b1;
  assign A         = w_issue ? r_addr : r_a_hold;

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
`default_nettype none
// Testbench for sram_stream_reader: sram model, queue-based reference stream,
// directed timing checks and randomized backpressure.
module tb_sram_stream_reader;

  localparam int DEPTH = 2048;

  logic        CLK;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        CEN;
  logic        WEN;
  logic [10:0] A;
  logic [15:0] Q;

  logic [15:0] mem [DEPTH];

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   n_last   = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  sram_stream_reader dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .CEN       (CEN),
    .WEN       (WEN),
    .A         (A),
    .Q         (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!CEN) Q <= mem[A];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: each accepted command expands into its address list
  // and word list; the DUT's reads and output beats are matched in order.
  always @(negedge CLK) begin
    if (!reset_n) begin
      exp_q.delete();
      addr_q.delete();
      n_out      = 0;
      prev_stall = 1'b0;
    end else begin
      if (!CEN) begin
        chk("WEN", WEN, 1);
        if (addr_q.size() == 0) chk("unexpected_issue", CEN, 1);
        else chk("A", A, addr_q.pop_front());
        n_out++;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", out_valid, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", out_data, e.d);
          chk("last", out_last, e.l);
        end
        if (out_last) n_last++;
        n_out--;
      end
      if (!CEN) chk("outstanding_le2", n_out <= 2, 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (cmd_valid && cmd_ready) begin
        for (int k = 0; k < int'(cmd_len); k++) begin
          int a;
          exp_t e;
          a   = (int'(cmd_addr) + k) % DEPTH;
          e.d = mem[a];
          e.l = (k == int'(cmd_len) - 1);
          exp_q.push_back(e);
          addr_q.push_back(a);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input int addr, input int len);
    step();
    cmd_valid = 1'b1;
    cmd_addr  = 11'(addr);
    cmd_len   = 12'(len);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge CLK);
    while (busy && n < 5000) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      n++;
    end
    chk(tag, busy, 0);
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    int   last_before;
    int   n;
    logic accepted;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);
    repeat (3) step();

    @(negedge CLK);
    chk("rst_CEN", CEN, 1);
    chk("rst_WEN", WEN, 1);
    chk("rst_A", A, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    step();
    reset_n = 1'b1;

    // Latency and streaming shape of a short burst
    step();
    cmd_valid = 1'b1;
    cmd_addr  = 11'd16;
    cmd_len   = 12'd4;
    @(negedge CLK);
    chk("t2_cmd_ready", cmd_ready, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      @(negedge CLK);
      chk("t2_out_valid", out_valid, (k >= 3 && k <= 6));
      chk("t2_out_last", out_last, (k == 6));
      chk("t2_busy", busy, (k <= 6));
      chk("t2_CEN", CEN, !(k >= 1 && k <= 4));
    end
    chk("t2_drained", exp_q.size(), 0);

    // Burst wrapping past the top of memory
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    send_cmd(2046, 4);
    wait_idle("t3_idle");
    chk("t3_drained", exp_q.size(), 0);

    // Backpressure: consumer stalls for cycles 3-10, then random
    step();
    cmd_valid = 1'b1;
    cmd_addr  = 11'($urandom_range(0, DEPTH - 1));
    cmd_len   = 12'd8;
    out_ready = 1'b1;
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      out_ready = (k >= 3 && k <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (k == 10) begin
        chk("t4_stall_CEN", CEN, 1);
        chk("t4_stall_valid", out_valid, 1);
      end
      n = k;
      if (k > 10 && !busy) break;
    end
    chk("t4_idle", busy, 0);
    out_ready = 1'b1;
    step();
    chk("t4_drained", exp_q.size(), 0);

    // Null command
    send_cmd(7, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("t5_CEN", CEN, 1);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_cmd_ready", cmd_ready, 1);
      step();
    end

    // Reset in the middle of a burst, then a clean burst
    send_cmd(50, 20);
    repeat (4) step();
    reset_n = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    chk("t1_CEN", CEN, 1);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_busy", busy, 0);
    step();
    reset_n = 1'b1;
    send_cmd(200, 5);
    wait_idle("t1_idle");
    chk("t1_drained", exp_q.size(), 0);

    // Full-memory burst with a second command stalled behind it
    last_before = n_last;
    send_cmd(5, 2048);
    repeat (10) step();
    cmd_valid = 1'b1;
    cmd_addr  = 11'd100;
    cmd_len   = 12'd3;
    accepted  = 1'b0;
    n = 0;
    while (n < 6000) begin
      @(negedge CLK);
      chk("t6_ready_vs_busy", cmd_ready, !busy);
      if (cmd_ready) accepted = 1'b1;
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      n++;
      if (accepted) begin
        cmd_valid = 1'b0;
        break;
      end
    end
    chk("t6_accepted", accepted, 1);
    chk("t6_stalled_long", n >= 2000, 1);
    wait_idle("t6_idle");
    chk("t6_last_count", n_last - last_before, 2);
    chk("t6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
